// File: rtl/int_reg_file_if.sv
// Bus bundle for int_reg_file: one write port, two read ports, address error flag.
// Parity signals exist only when REG_FILE_PARITY_EN is defined.
interface int_reg_file_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 3
);
    logic              clr;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_a_en;
    logic [ADDR_W-1:0] rd_a_addr;
    logic [DATA_W-1:0] rd_a_data;
    logic              rd_a_valid;
    logic              rd_b_en;
    logic [ADDR_W-1:0] rd_b_addr;
    logic [DATA_W-1:0] rd_b_data;
    logic              rd_b_valid;
    logic              addr_err;
`ifdef REG_FILE_PARITY_EN
    logic              par_inj;
    logic              rd_a_perr;
    logic              rd_b_perr;
`endif

    modport master (
        output clr, wr_en, wr_addr, wr_data,
        output rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
        input  rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, addr_err
`ifdef REG_FILE_PARITY_EN
        , output par_inj
        , input  rd_a_perr, rd_b_perr
`endif
    );

    modport slave (
        input  clr, wr_en, wr_addr, wr_data,
        input  rd_a_en, rd_a_addr, rd_b_en, rd_b_addr,
        output rd_a_data, rd_a_valid, rd_b_data, rd_b_valid, addr_err
`ifdef REG_FILE_PARITY_EN
        , input  par_inj
        , output rd_a_perr, rd_b_perr
`endif
    );
endinterface

// File: rtl/int_reg_file.sv
// General-purpose register file: 1 write / 2 registered read ports, write-first bypass,
// synchronous clear, out-of-range detection. Optional parity via REG_FILE_PARITY_EN.
module int_reg_file #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 6,
    parameter int unsigned ADDR_W = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    int_reg_file_if.slave bus
);
    localparam int unsigned NPORT  = 2;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q [NPORT];
    logic [DATA_W-1:0] rd_data_d [NPORT];
    logic [NPORT-1:0]  rd_valid_q;
    logic              addr_err_q;
    logic              addr_err_d;

    logic [ADDR_W-1:0] rd_addr [NPORT];
    logic [NPORT-1:0]  rd_en;
    logic              wr_ok;

    assign rd_addr[0] = bus.rd_a_addr;
    assign rd_addr[1] = bus.rd_b_addr;
    assign rd_en      = {bus.rd_b_en, bus.rd_a_en};

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < DEPTH_L;
    endfunction

`ifdef REG_FILE_PARITY_EN
    logic [DEPTH-1:0] par_q;
    logic [NPORT-1:0] rd_perr_q;
    logic [NPORT-1:0] rd_perr_d;
`endif

    // Next read data per port: clear first, then range check, then bypass, then storage
    always_comb begin
        wr_ok      = bus.wr_en && !bus.clr && in_range(bus.wr_addr);
        addr_err_d = bus.wr_en && !in_range(bus.wr_addr);
`ifdef REG_FILE_PARITY_EN
        rd_perr_d  = '0;
`endif
        for (int unsigned p = 0; p < NPORT; p++) begin
            logic [DATA_W-1:0] stored;
            logic              stored_par;
            logic              bypass;
            stored     = '0;
            stored_par = 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (rd_addr[p] == ADDR_W'(i)) begin
                    stored = mem_q[i];
`ifdef REG_FILE_PARITY_EN
                    stored_par = par_q[i];
`endif
                end
            end
            bypass = bus.wr_en && (rd_addr[p] == bus.wr_addr);
            if (bus.clr || !in_range(rd_addr[p])) begin
                rd_data_d[p] = '0;
            end else if (bypass) begin
                rd_data_d[p] = bus.wr_data;
            end else begin
                rd_data_d[p] = stored;
            end
`ifdef REG_FILE_PARITY_EN
            rd_perr_d[p] = !bus.clr && in_range(rd_addr[p]) && !bypass
                           && ((^stored) != stored_par);
`else
            if (stored_par) rd_data_d[p] = rd_data_d[p];
`endif
            if (rd_en[p] && !in_range(rd_addr[p])) addr_err_d = 1'b1;
        end
    end

    // Storage array
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (bus.clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                if (bus.wr_addr == ADDR_W'(i)) mem_q[i] <= bus.wr_data;
        end
    end

`ifdef REG_FILE_PARITY_EN
    // Parity bit stored alongside each entry; par_inj corrupts it for fault testing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_q     <= '0;
            rd_perr_q <= '0;
        end else begin
            if (bus.clr) begin
                par_q <= '0;
            end else if (wr_ok) begin
                for (int unsigned i = 0; i < DEPTH; i++)
                    if (bus.wr_addr == ADDR_W'(i)) par_q[i] <= (^bus.wr_data) ^ bus.par_inj;
            end
            for (int unsigned p = 0; p < NPORT; p++)
                if (rd_en[p]) rd_perr_q[p] <= rd_perr_d[p];
        end
    end

    assign bus.rd_a_perr = rd_perr_q[0];
    assign bus.rd_b_perr = rd_perr_q[1];
`endif

    // Read output registers; data holds when the port is idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned p = 0; p < NPORT; p++) rd_data_q[p] <= '0;
            rd_valid_q <= '0;
            addr_err_q <= 1'b0;
        end else begin
            for (int unsigned p = 0; p < NPORT; p++)
                if (rd_en[p]) rd_data_q[p] <= rd_data_d[p];
            rd_valid_q <= rd_en;
            addr_err_q <= addr_err_d;
        end
    end

    assign bus.rd_a_data  = rd_data_q[0];
    assign bus.rd_b_data  = rd_data_q[1];
    assign bus.rd_a_valid = rd_valid_q[0];
    assign bus.rd_b_valid = rd_valid_q[1];
    assign bus.addr_err   = addr_err_q;
endmodule

// File: tb/tb_int_reg_file.sv
// Directed self-checking bench for int_reg_file (DATA_W=8, DEPTH=6, ADDR_W=3).
module tb_int_reg_file;
    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;

    int_reg_file_if #(.DATA_W(8), .ADDR_W(3)) rf_if ();

    int_reg_file #(.DATA_W(8), .DEPTH(6), .ADDR_W(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (rf_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_if.clr       = 1'b0;
        rf_if.wr_en     = 1'b0;
        rf_if.wr_addr   = '0;
        rf_if.wr_data   = '0;
        rf_if.rd_a_en   = 1'b0;
        rf_if.rd_a_addr = '0;
        rf_if.rd_b_en   = 1'b0;
        rf_if.rd_b_addr = '0;
`ifdef REG_FILE_PARITY_EN
        rf_if.par_inj   = 1'b0;
`endif
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        rf_if.wr_en   = 1'b1;
        rf_if.wr_addr = a;
        rf_if.wr_data = d;
    endtask

    task automatic rda(input logic [2:0] a);
        rf_if.rd_a_en   = 1'b1;
        rf_if.rd_a_addr = a;
    endtask

    task automatic rdb(input logic [2:0] a);
        rf_if.rd_b_en   = 1'b1;
        rf_if.rd_b_addr = a;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic [7:0] exp_mem [6];

    initial begin
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_a_data",  32'(rf_if.rd_a_data),  32'h00);
        chk("rst_b_data",  32'(rf_if.rd_b_data),  32'h00);
        chk("rst_a_valid", 32'(rf_if.rd_a_valid), 32'h0);
        chk("rst_b_valid", 32'(rf_if.rd_b_valid), 32'h0);
        chk("rst_err",     32'(rf_if.addr_err),   32'h0);
        rst_n = 1'b1;

        // Reads straight after reset
        rda(3'd0); rdb(3'd5);
        tick();
        chk("t1_a_data",  32'(rf_if.rd_a_data),  32'h00);
        chk("t1_b_data",  32'(rf_if.rd_b_data),  32'h00);
        chk("t1_a_valid", 32'(rf_if.rd_a_valid), 32'h1);
        chk("t1_b_valid", 32'(rf_if.rd_b_valid), 32'h1);
        chk("t1_err",     32'(rf_if.addr_err),   32'h0);

        // Plain writes then dual read, then idle hold
        idle(); wr(3'd2, 8'hA5); tick();
        idle(); wr(3'd5, 8'h3C); tick();
        idle(); rda(3'd2); rdb(3'd5); tick();
        chk("t2_a_data",  32'(rf_if.rd_a_data),  32'hA5);
        chk("t2_b_data",  32'(rf_if.rd_b_data),  32'h3C);
        chk("t2_a_valid", 32'(rf_if.rd_a_valid), 32'h1);
        idle(); tick();
        chk("t2_idle_a_valid", 32'(rf_if.rd_a_valid), 32'h0);
        chk("t2_idle_b_valid", 32'(rf_if.rd_b_valid), 32'h0);
        chk("t2_hold_a",       32'(rf_if.rd_a_data),  32'hA5);
        chk("t2_hold_b",       32'(rf_if.rd_b_data),  32'h3C);

        // Bypass, then clear beating a write and a bypass
        idle(); wr(3'd3, 8'h77); rda(3'd3); tick();
        chk("t3_bypass_a", 32'(rf_if.rd_a_data), 32'h77);
        idle(); rf_if.clr = 1'b1; wr(3'd1, 8'h11); rdb(3'd1); tick();
        chk("t3_clr_b",       32'(rf_if.rd_b_data),  32'h00);
        chk("t3_clr_b_valid", 32'(rf_if.rd_b_valid), 32'h1);
        idle(); rdb(3'd1); rda(3'd3); tick();
        chk("t3_after_clr_r1", 32'(rf_if.rd_b_data), 32'h00);
        chk("t3_after_clr_r3", 32'(rf_if.rd_a_data), 32'h00);

        // Out-of-range accesses
        idle(); wr(3'd0, 8'h10); tick();
        idle(); wr(3'd5, 8'h55); tick();
        idle(); wr(3'd4, 8'h4B); rdb(3'd4); tick();
        chk("t4_bypass_b", 32'(rf_if.rd_b_data), 32'h4B);
        idle(); wr(3'd6, 8'hFF); rda(3'd7); tick();
        chk("t4_err",     32'(rf_if.addr_err),   32'h1);
        chk("t4_a_data",  32'(rf_if.rd_a_data),  32'h00);
        chk("t4_a_valid", 32'(rf_if.rd_a_valid), 32'h1);
        idle(); tick();
        chk("t4_err_clear", 32'(rf_if.addr_err), 32'h0);
        idle(); wr(3'd7, 8'hEE); tick();
        chk("t4_err_wr_only", 32'(rf_if.addr_err), 32'h1);
        idle(); rdb(3'd6); tick();
        chk("t4_err_b",    32'(rf_if.addr_err),  32'h1);
        chk("t4_b_oor",    32'(rf_if.rd_b_data), 32'h00);
        exp_mem = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h4B, 8'h55};
        for (int i = 0; i < 6; i++) begin
            idle(); rda(3'(i)); rdb(3'(i)); tick();
            chk($sformatf("t4_scan_a_r%0d", i), 32'(rf_if.rd_a_data), 32'(exp_mem[i]));
            chk($sformatf("t4_scan_b_r%0d", i), 32'(rf_if.rd_b_data), 32'(exp_mem[i]));
        end

        // Asynchronous reset in the middle of traffic
        idle(); wr(3'd2, 8'h22); tick();
        idle(); rda(3'd2); rdb(3'd5); tick();
        chk("t5_pre_a", 32'(rf_if.rd_a_data), 32'h22);
        chk("t5_pre_b", 32'(rf_if.rd_b_data), 32'h55);
        wr(3'd4, 8'h44);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t5_async_a",       32'(rf_if.rd_a_data),  32'h00);
        chk("t5_async_b",       32'(rf_if.rd_b_data),  32'h00);
        chk("t5_async_a_valid", 32'(rf_if.rd_a_valid), 32'h0);
        chk("t5_async_b_valid", 32'(rf_if.rd_b_valid), 32'h0);
        idle(); tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            idle(); rda(3'(i)); rdb(3'(5 - i)); tick();
            chk($sformatf("t5_post_a_r%0d", i), 32'(rf_if.rd_a_data), 32'h00);
            chk($sformatf("t5_post_b_r%0d", 5 - i), 32'(rf_if.rd_b_data), 32'h00);
        end

`ifdef REG_FILE_PARITY_EN
        // Injected parity fault is reported, clean rewrite clears it
        idle(); wr(3'd4, 8'h01); rf_if.par_inj = 1'b1; tick();
        idle(); rda(3'd4); tick();
        chk("t6_perr_inj",  32'(rf_if.rd_a_perr), 32'h1);
        chk("t6_data_inj",  32'(rf_if.rd_a_data), 32'h01);
        idle(); wr(3'd4, 8'h01); tick();
        idle(); rda(3'd4); tick();
        chk("t6_perr_clean", 32'(rf_if.rd_a_perr), 32'h0);
`endif

        idle(); tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
